// File: rtl/large_array_read.sv
// Read-side model of the LargeArray state: a write port to load the array and a READ path
// that returns array[addr] after READ_LATENCY cycles, plus a cycles-since-READ counter.
module large_array_read #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1,   // legal range 1..4
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  input  logic              ren,
  output logic              decode_read,
  output logic              valid,
  output logic [DATA_W-1:0] odata,
  output logic              odata_valid,
  output logic [CNT_W-1:0]  start_cnt
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic                    issue;
  logic                    do_write;
  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] vld_d;
  logic [DATA_W-1:0]       dat_q [READ_LATENCY];
  logic [DATA_W-1:0]       dat_d [READ_LATENCY];
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;

  // Write wins over read: ren&wen together is a WRITE, never a READ.
  assign decode_read = ren & ~wen;
  assign valid       = 1'b1;
  assign issue       = start & decode_read;
  assign do_write    = start & wen;

  // Array is deliberately not reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst && do_write) begin
      mem_q[addr] <= data;
    end
  end

  always_comb begin
    vld_d[0] = issue;
    dat_d[0] = mem_q[addr];
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // The last stage doubles as the odata register: it only loads on a valid word so
  // odata holds between reads. odata_valid is high for exactly one cycle per READ,
  // with no back-pressure; the consumer must take the word in that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        if ((i < READ_LATENCY - 1) || vld_d[i]) begin
          dat_q[i] <= dat_d[i];
        end
      end
    end
  end

  // Zero means "no READ seen yet" and holds; the counter saturates at CNT_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      if (issue) begin
        cnt_d = CNT_ONE;
      end else if ((cnt_q != '0) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign odata       = dat_q[READ_LATENCY-1];
  assign odata_valid = vld_q[READ_LATENCY-1];
  assign start_cnt   = cnt_q;

endmodule

// File: tb/tb_large_array_read.sv
// Bench for large_array_read: two instances (latency 1 and 3) share one stimulus stream;
// a reference array and counter model feed expected-read queues checked at each negedge.
module tb_large_array_read;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] addr;
  logic [7:0] data;
  logic       wen;
  logic       ren;

  logic       d1_decode_read, d1_valid, d1_odata_valid;
  logic [7:0] d1_odata, d1_start_cnt;
  logic       d3_decode_read, d3_valid, d3_odata_valid;
  logic [7:0] d3_odata, d3_start_cnt;

  large_array_read #(.ADDR_W(4), .DATA_W(8), .READ_LATENCY(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .data(data), .wen(wen), .ren(ren),
    .decode_read(d1_decode_read), .valid(d1_valid), .odata(d1_odata),
    .odata_valid(d1_odata_valid), .start_cnt(d1_start_cnt)
  );

  large_array_read #(.ADDR_W(4), .DATA_W(8), .READ_LATENCY(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .data(data), .wen(wen), .ren(ren),
    .decode_read(d3_decode_read), .valid(d3_valid), .odata(d3_odata),
    .odata_valid(d3_odata_valid), .start_cnt(d3_start_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and reference model
  logic [7:0] exp1_q[$];
  logic [7:0] exp3_q[$];
  logic [7:0] model_mem [16];
  logic [7:0] exp_cnt;
  int         checks;
  int         errors;
  int         cyc;
  int         pulses1, pulses3;
  int         last_t1, prev_t1, last_t3, prev_t3;

  task automatic sample_outputs();
    logic [7:0] e;
    if (d1_odata_valid) begin
      pulses1++;
      prev_t1 = last_t1;
      last_t1 = cyc;
      checks++;
      if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected: odata_valid with odata=%02h, required no pulse", d1_odata);
      end else begin
        e = exp1_q.pop_front();
        if (d1_odata !== e) begin
          errors++;
          $display("FAIL sb1_data: odata=%02h required %02h", d1_odata, e);
        end
      end
    end
    if (d3_odata_valid) begin
      pulses3++;
      prev_t3 = last_t3;
      last_t3 = cyc;
      checks++;
      if (exp3_q.size() == 0) begin
        errors++;
        $display("FAIL sb3_unexpected: odata_valid with odata=%02h, required no pulse", d3_odata);
      end else begin
        e = exp3_q.pop_front();
        if (d3_odata !== e) begin
          errors++;
          $display("FAIL sb3_data: odata=%02h required %02h", d3_odata, e);
        end
      end
    end
    checks++;
    if (d1_start_cnt !== exp_cnt || d3_start_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL start_cnt: got %0d/%0d required %0d", d1_start_cnt, d3_start_cnt, exp_cnt);
    end
    cyc++;
  endtask

  // driver: applies inputs for one cycle, updates the model, samples at the negedge
  task automatic drive_cycle(input logic st, input logic r, input logic w,
                             input logic [3:0] a, input logic [7:0] d);
    start = st;
    ren   = r;
    wen   = w;
    addr  = a;
    data  = d;
    if (rst && st) begin
      if (w) model_mem[a] = d;
      if (r && !w) begin
        exp1_q.push_back(model_mem[a]);
        exp3_q.push_back(model_mem[a]);
        exp_cnt = 8'd1;
      end else if (exp_cnt != 8'd0 && exp_cnt != 8'd255) begin
        exp_cnt = exp_cnt + 8'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    sample_outputs();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp1_q.size() != 0 || exp3_q.size() != 0) && n < 12) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
      n++;
    end
    checks++;
    if (exp1_q.size() != 0 || exp3_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d/%0d reads, required 0/0",
               exp1_q.size(), exp3_q.size());
      exp1_q.delete();
      exp3_q.delete();
    end
  endtask

  task automatic test_reset();
    logic r, w;
    rst = 1'b0;
    exp_cnt = 8'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      drive_cycle(1'b1, r, w, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      checks++;
      if (d1_odata !== 8'h00 || d1_odata_valid !== 1'b0 || d3_odata !== 8'h00 ||
          d3_odata_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: odata=%02h/%02h vld=%b/%b required 00/00 0/0",
                 d1_odata, d3_odata, d1_odata_valid, d3_odata_valid);
      end
      checks++;
      if (d1_decode_read !== (r & ~w) || d1_valid !== 1'b1 || d3_valid !== 1'b1) begin
        errors++;
        $display("FAIL decode: decode_read=%b valid=%b/%b required %b 1/1",
                 d1_decode_read, d1_valid, d3_valid, r & ~w);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    int t_iss;
    int p1;
    p1 = pulses1;
    drive_cycle(1'b1, 1'b0, 1'b1, 4'd3, 8'hA5);
    drive_cycle(1'b1, 1'b1, 1'b0, 4'd3, 8'h00);
    t_iss = cyc - 1;
    checks++;
    if (d1_start_cnt !== 8'd1) begin
      errors++;
      $display("FAIL wr_cnt1: start_cnt=%0d required 1", d1_start_cnt);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    checks++;
    if (d1_start_cnt !== 8'd2) begin
      errors++;
      $display("FAIL wr_cnt2: start_cnt=%0d required 2", d1_start_cnt);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    checks++;
    if (d3_start_cnt !== 8'd3) begin
      errors++;
      $display("FAIL wr_cnt3: start_cnt=%0d required 3", d3_start_cnt);
    end
    drain();
    checks++;
    if (last_t1 !== t_iss || last_t3 !== t_iss + 2) begin
      errors++;
      $display("FAIL wr_latency: pulse at %0d/%0d required %0d/%0d",
               last_t1, last_t3, t_iss, t_iss + 2);
    end
    checks++;
    if (pulses1 !== p1 + 1) begin
      errors++;
      $display("FAIL wr_pulse_count: %0d pulses required 1", pulses1 - p1);
    end
  endtask

  task automatic test_back_to_back();
    drive_cycle(1'b1, 1'b0, 1'b1, 4'd15, 8'h5A);
    drive_cycle(1'b1, 1'b1, 1'b0, 4'd3, 8'h00);
    drive_cycle(1'b1, 1'b1, 1'b0, 4'd15, 8'h00);
    drain();
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    checks++;
    if (last_t1 - prev_t1 !== 1 || last_t3 - prev_t3 !== 1) begin
      errors++;
      $display("FAIL b2b_gap: gaps %0d/%0d required 1/1", last_t1 - prev_t1, last_t3 - prev_t3);
    end
    checks++;
    if (d1_odata !== 8'h5A || d3_odata !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_hold: odata=%02h/%02h required 5a", d1_odata, d3_odata);
    end
  endtask

  task automatic test_collision();
    int p1, p3;
    p1 = pulses1;
    p3 = pulses3;
    drive_cycle(1'b1, 1'b1, 1'b1, 4'd7, 8'h3C);
    checks++;
    if (d1_decode_read !== 1'b0 || d3_decode_read !== 1'b0) begin
      errors++;
      $display("FAIL coll_decode: decode_read=%b/%b required 0", d1_decode_read, d3_decode_read);
    end
    repeat (4) drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    checks++;
    if (pulses1 !== p1 || pulses3 !== p3 || d1_start_cnt == 8'd5) begin
      errors++;
      $display("FAIL coll_no_read: pulses %0d/%0d cnt=%0d required 0/0 and no reload",
               pulses1 - p1, pulses3 - p3, d1_start_cnt);
    end
    drive_cycle(1'b1, 1'b1, 1'b0, 4'd7, 8'h00);
    drain();
    checks++;
    if (d1_odata !== 8'h3C || d3_odata !== 8'h3C) begin
      errors++;
      $display("FAIL coll_readback: odata=%02h/%02h required 3c", d1_odata, d3_odata);
    end
  endtask

  task automatic test_start_gating();
    int p1, p3;
    logic [7:0] frozen;
    p1 = pulses1;
    p3 = pulses3;
    frozen = exp_cnt;
    repeat (3) drive_cycle(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    checks++;
    if (pulses1 !== p1 || pulses3 !== p3 || d1_start_cnt !== frozen) begin
      errors++;
      $display("FAIL gate_start0: pulses %0d/%0d cnt=%0d required 0/0 cnt=%0d",
               pulses1 - p1, pulses3 - p3, d1_start_cnt, frozen);
    end
    drive_cycle(1'b1, 1'b1, 1'b0, 4'd15, 8'h00);
    drain();
    for (int k = 1; k <= 300; k++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
      if (k == 253 || k == 254 || k == 300) begin
        checks++;
        if (d3_start_cnt !== ((k == 253) ? 8'd254 : 8'd255)) begin
          errors++;
          $display("FAIL sat_cnt_k%0d: start_cnt=%0d required %0d", k, d3_start_cnt,
                   (k == 253) ? 254 : 255);
        end
      end
    end
    drive_cycle(1'b1, 1'b1, 1'b0, 4'd3, 8'h00);
    checks++;
    if (d1_start_cnt !== 8'd1) begin
      errors++;
      $display("FAIL sat_reload: start_cnt=%0d required 1", d1_start_cnt);
    end
    drain();
  endtask

  task automatic test_midflight_reset();
    int p3;
    drive_cycle(1'b1, 1'b1, 1'b0, 4'd3, 8'h00);
    p3 = pulses3;
    rst = 1'b0;
    exp3_q.delete();
    exp_cnt = 8'd0;
    #1;
    checks++;
    if (d3_odata !== 8'h00 || d3_start_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_async: odata=%02h cnt=%0d required 00 0", d3_odata, d3_start_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      checks++;
      if (d3_odata_valid !== 1'b0 || d3_odata !== 8'h00) begin
        errors++;
        $display("FAIL mid_hold: vld=%b odata=%02h required 0 00", d3_odata_valid, d3_odata);
      end
    end
    rst = 1'b1;
    repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    checks++;
    if (pulses3 !== p3) begin
      errors++;
      $display("FAIL mid_discard: %0d pulses for discarded read, required 0", pulses3 - p3);
    end
    drive_cycle(1'b1, 1'b1, 1'b0, 4'd3, 8'h00);
    drain();
    checks++;
    if (d3_odata !== 8'hA5 || d1_odata !== 8'hA5) begin
      errors++;
      $display("FAIL mid_retained: odata=%02h/%02h required a5", d1_odata, d3_odata);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    pulses1 = 0;
    pulses3 = 0;
    last_t1 = 0;
    prev_t1 = 0;
    last_t3 = 0;
    prev_t3 = 0;
    exp_cnt = 8'd0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    rst   = 1'b1;
    start = 1'b0;
    ren   = 1'b0;
    wen   = 1'b0;
    addr  = 4'd0;
    data  = 8'd0;
    #2;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_collision();
    test_start_gating();
    test_midflight_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/large_array_read.md
Name: large_array_read

Overview:
- Read-side instruction model for the 16-entry LargeArray state, complementing the existing WRITE instruction model.
- Decodes READ (ren=1, wen=0) and returns the addressed word on odata after a fixed pipeline latency, with a one-cycle odata_valid pulse.
- Keeps a write port so the bench and the composed model can load the array.
- Maintains a saturating cycles-since-start counter on READ decode, used by property checks.

Parameters:
- ADDR_W, 4: address width; array depth = 2**ADDR_W.
- DATA_W, 8: word width.
- READ_LATENCY, 1: cycles from READ issue to odata_valid. Legal range is 1..4.
- CNT_W, 8: width of the start counter. Saturates at 2**CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  instruction-start qualifier. Issue, write and counter update happen only when start=1.
- addr  in  ADDR_W  read/write address.
- data  in  DATA_W  write data.
- wen  in  1  write request.
- ren  in  1  read request.
- decode_read  out  1  combinational: ren==1 && wen==0.
- valid  out  1  constant 1 (model valid).
- odata  out  DATA_W  read data; holds its last value between reads.
- odata_valid  out  1  one-cycle pulse when odata carries a newly returned word.
- start_cnt  out  CNT_W  cycles since the most recent accepted READ.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - odata=0, odata_valid=0, start_cnt=0.
  - All pipeline valid bits cleared; pipeline data cleared to 0.
  - Array contents are not reset and retain their values.
- Release of reset is sampled at the next rising edge.
- Write: at a rising edge with start=1 and wen=1, array[addr] <= data.
  - WRITE has priority: with ren=1 and wen=1 together, the write is performed and no READ is issued.
- Issue: at a rising edge with start=1 and decode_read=1, array[addr] is captured into pipeline stage 1 with its valid bit set.
  - The captured value is the pre-edge array contents.
  - A write in cycle N is visible to a read issued in cycle N+1 or later.
- Pipeline:
  - Stages 1..READ_LATENCY shift every cycle, independent of start; in-flight reads always complete.
  - When the last stage is valid, odata <= stage data and odata_valid=1 for exactly that cycle.
  - Otherwise odata_valid=0 and odata holds.
- Latency: a READ issued at edge N gives odata_valid=1 in the cycle after edge N+READ_LATENCY-1.
  - For READ_LATENCY=1, the data is registered at the issue edge and visible right after it.
- Throughput: one READ per cycle. Back-to-back reads produce back-to-back valid pulses in issue order.
- start_cnt, updated only at edges with start=1:
  - Accepted READ → 1.
  - Else if 1 <= start_cnt < max → increment.
  - Else hold. 0 holds until the first READ; max (255) saturates.
  - A new READ while counting reloads to 1.
- start=0: no issue, no write, start_cnt frozen; the pipeline still drains.
- Reset during an in-flight read: the read is discarded and odata_valid never pulses for it.
- Addresses cover the full range 0..2**ADDR_W-1 with no out-of-range case.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with random ren/wen → odata=0x00, odata_valid=0, start_cnt=0 throughout.
2. Write then read: start=1, wen=1, addr=3, data=0xA5; next cycle ren=1, addr=3 → odata=0xA5 with a one-cycle odata_valid after READ_LATENCY; start_cnt reads 1, 2, 3 on following edges.
3. Back-to-back reads (array[3]=0xA5, array[15]=0x5A preloaded): ren on consecutive cycles for addr 3 then addr 15 → two consecutive valid pulses, 0xA5 then 0x5A; odata holds 0x5A afterwards.
4. Collision: ren=1, wen=1, addr=7, data=0x3C → decode_read=0, no valid pulse, start_cnt not reloaded; a later read of addr 7 returns 0x3C.
5. Start gating and saturation:
   - start=0 with ren=1 → no valid pulse, start_cnt frozen.
   - After one READ, 300 cycles with start=1 and no READ → start_cnt reaches and holds 255.
   - A new READ reloads start_cnt to 1.
6. Mid-flight reset: READ_LATENCY=3, issue read of 0xA5, then assert rst low between edges → odata_valid never asserts and odata=0. After release, a read of addr 3 returns 0xA5 (array retained).
